// File: rtl/filterbank_pkg.sv
// Shared types and default geometry for the filterbank input stage.
package filterbank_pkg;
    localparam int TAP_WIDTH    = 14;
    localparam int NUM_TAPS     = 119;
    localparam int DECIM_FACTOR = 60;
    localparam int SNAP_PHASE   = 59;

    typedef logic signed [TAP_WIDTH-1:0] tap_t;
    typedef tap_t [NUM_TAPS-1:0]         tap_bus_t;
endpackage

// File: rtl/tap_shift_reg.sv
// DEPTH-tap shift line, newest sample at tap 0; one cycle per shift, clear has priority.
// line_next exposes the post-shift contents so a snapshot can include the sample being accepted.
module tap_shift_reg
    import filterbank_pkg::*;
#(
    parameter int WIDTH = TAP_WIDTH,
    parameter int DEPTH = NUM_TAPS
) (
    input  logic                   clk_en,
    input  logic                   reset,
    input  logic                   shift,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       data,
    output logic [DEPTH*WIDTH-1:0] line,
    output logic [DEPTH*WIDTH-1:0] line_next
);
    assign line_next = {line[(DEPTH-1)*WIDTH-1:0], data};

    always_ff @(posedge clk_en) begin
        if (reset || clear) begin
            line <= '0;
        end else if (shift) begin
            line <= line_next;
        end
    end
endmodule

// File: rtl/tap_frame_buffer.sv
// Delay line plus decimated snapshot with frame handshake; snapshot visible one cycle after the accepting edge.
// Snapshot is held until frame_ack; an unacked snapshot that gets overwritten raises sticky overrun.
module tap_frame_buffer
    import filterbank_pkg::*;
#(
    parameter int WIDTH = TAP_WIDTH,
    parameter int DEPTH = NUM_TAPS,
    parameter int DECIM = DECIM_FACTOR,
    parameter int PHASE = SNAP_PHASE,
    parameter int CNT_W = 16
) (
    input  logic                     clk_en,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic signed [WIDTH-1:0]  in_data,
    input  logic                     flush,
    input  logic                     frame_ack,
    input  logic                     overrun_clr,
    output logic [DEPTH*WIDTH-1:0]   taps_out,
    output logic                     frame_valid,
    output logic [$clog2(DECIM)-1:0] phase,
    output logic [CNT_W-1:0]         frame_count,
    output logic                     overrun
);
    localparam int PW = $clog2(DECIM);
    localparam logic [PW-1:0] SNAP_AT = PW'(PHASE);
    localparam logic [PW-1:0] LAST    = PW'(DECIM - 1);

    logic                   accept;
    logic                   snap_event;
    logic [DEPTH*WIDTH-1:0] line;
    logic [DEPTH*WIDTH-1:0] line_next;

    assign accept     = in_valid & ~flush;
    assign snap_event = accept & (phase == SNAP_AT);

    tap_shift_reg #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_line (
        .clk_en    (clk_en),
        .reset     (reset),
        .shift     (accept),
        .clear     (flush),
        .data      (in_data),
        .line      (line),
        .line_next (line_next)
    );

    always_ff @(posedge clk_en) begin
        if (reset) begin
            phase       <= '0;
            taps_out    <= '0;
            frame_valid <= 1'b0;
            frame_count <= '0;
            overrun     <= 1'b0;
        end else begin
            if (flush) begin
                phase <= '0;
            end else if (in_valid) begin
                phase <= (phase == LAST) ? '0 : phase + PW'(1);
            end

            if (snap_event) begin
                taps_out    <= line_next;
                frame_valid <= 1'b1;
                frame_count <= frame_count + CNT_W'(1);
                // Overwriting a pending, unacked frame is the only overrun source; it beats a clear.
                if (frame_valid && !frame_ack) begin
                    overrun <= 1'b1;
                end else if (overrun_clr) begin
                    overrun <= 1'b0;
                end
            end else begin
                if (frame_ack) begin
                    frame_valid <= 1'b0;
                end
                if (overrun_clr) begin
                    overrun <= 1'b0;
                end
            end
        end
    end
endmodule
